public_test_capture: RTL and testbench
======================================

# public_test_capture

Downstream capture stage for the `public_test` sequential garbling netlist. It samples the block's 32-bit `o` word on each of a programmed number of garbling clock cycles and buffers the samples in a small FIFO. It drains them over a valid/ready stream to the output serializer. It also flags lost samples and, optionally, keeps a running XOR checksum of the captured words.

## Interface
Parameters:
- `DATA_W`, 32, width of captured word (matches `o`)
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `CNT_W`, 16, width of cycle counter

Ports:
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin capture run; sampled only in IDLE
- `num_cycles` in CNT_W: number of words to capture; sampled with `start`
- `o_in` in DATA_W: `o` output of the garbling stage
- `out_data` out DATA_W: FIFO head word
- `out_valid` out 1: FIFO non-empty
- `out_ready` in 1: consumer accepts head when high with `out_valid`
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse at run completion
- `overflow` out 1: sticky; a sample was dropped in the current or last run
- `checksum` out DATA_W: XOR of all sampled words in the run; present only with `PUBLIC_TEST_CAPTURE_CHECKSUM_EN`

## Operation
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE:
  - `start`=1 loads `remaining`←`num_cycles`, clears `overflow` and `checksum`.
  - Goes to CAPTURE, or to DRAIN if `num_cycles`=0.
- CAPTURE:
  - Every cycle samples `o_in` and pushes it into the FIFO, then decrements `remaining`.
  - On the cycle that `remaining` goes 1→0, goes to DRAIN.
- FIFO full with no pop in the same cycle: the sample is dropped, `overflow`←1, and the counter still decrements.
- FIFO full with a pop in the same cycle: the push succeeds and nothing is dropped.
- DRAIN: no pushes. Moves to DONE when the FIFO is empty, including the case where the last pop happens this cycle.
- DONE: `done`=1 for exactly one cycle, then IDLE. `overflow` and `checksum` hold until the next `start`.
- Pops (`out_valid`&&`out_ready`) are legal in every state. `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `start` outside IDLE is ignored. `num_cycles` is not re-sampled during a run.
- Counter and FIFO pointers wrap modulo their widths. Occupancy counter width is log2(DEPTH)+1.

## Timing
- All outputs are registered except `out_data`, which is driven from FIFO storage at the read pointer.
- Reset values: `out_valid`=0, `busy`=0, `done`=0, `overflow`=0, `checksum`=0, `out_data`=0. State is IDLE and FIFO is empty.
- `start` high at edge t → `busy`=1 from t+1. First sample is `o_in` at edge t+1.
- A word pushed at edge k gives `out_valid`=1 in cycle k+1 (one-cycle latency).
- A run of N≥1 samples with an always-ready consumer: last push at edge t+N, `done` pulse in cycle t+N+2, IDLE at t+N+3.
- `rst` mid-run: the next edge returns to IDLE and discards FIFO contents; no `done` pulse.

## Configuration
- `PUBLIC_TEST_CAPTURE_CHECKSUM_EN` defined:
  - `checksum` port exists.
  - Each sampled word, dropped or not, is XORed in at the same edge as its push.
  - Value is valid from the cycle `done` is high.
- Undefined: the port and its register are omitted. All other behaviour is identical.

## Structure
- Package `public_test_capture_pkg`: state enum (IDLE, CAPTURE, DRAIN, DONE) and default constants for DATA_W/DEPTH/CNT_W.
- One sub-module, `capture_fifo`: synchronous FIFO with parameters DATA_W and DEPTH.
  - Ports: push/pop/full/empty/head.
  - Simultaneous push and pop is allowed when full.
- The top level holds the FSM, counter, overflow flag and checksum.

## Test plan
- `num_cycles`=4, `o_in`=0x11,0x22,0x33,0x44, `out_ready`=1 → stream 0x11,0x22,0x33,0x44 in order; `done` once; `overflow`=0; checksum 0x44.
- `num_cycles`=10, DEPTH=8, `out_ready`=0 until done is pending → first 8 words retained, `overflow`=1. Raising `out_ready` drains 8 words, then `done`.
- `num_cycles`=0 → no `out_valid`; `done` pulse 2 cycles after `start`; `busy` high for exactly 2 cycles.
- Second `start` during CAPTURE with `num_cycles`=3 → ignored; original 5-word run completes normally.
- `rst` asserted after 3 of 6 samples → next cycle `busy`=0, `out_valid`=0, `overflow`=0, no `done`.
- FIFO full while CAPTURE continues with `out_ready`=1 every cycle, `num_cycles`=20 → no drops; 20 words out; `overflow`=0.

Source files
------------

// File: rtl/public_test_capture_pkg.sv
// Shared types and default sizing for the public_test capture stage.
package public_test_capture_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO for captured words; a push is accepted when full if a pop
// happens in the same cycle. Flags are registered from the next occupancy.
module capture_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              one_left_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [OCC_W-1:0]  count_q;
    logic [OCC_W-1:0]  count_d;
    logic              full_q;
    logic              empty_q;
    logic              one_left_q;
    logic              push_ok_c;
    logic              pop_ok_c;

    assign pop_ok_c  = pop_i && !empty_q;
    assign push_ok_c = push_i && (!full_q || pop_ok_c);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            one_left_q <= 1'b0;
        end else begin
            if (push_ok_c) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q    <= count_d;
            full_q     <= (count_d == OCC_W'(DEPTH));
            empty_q    <= (count_d == '0);
            one_left_q <= (count_d == OCC_W'(1));
        end
    end

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign one_left_o = one_left_q;
    assign head_o     = mem_q[rd_ptr_q];

endmodule

// File: rtl/public_test_capture.sv
// Capture stage for the public_test garbling netlist: samples o_in for a
// programmed number of cycles into a FIFO and streams it out.
// Optional feature macro: PUBLIC_TEST_CAPTURE_CHECKSUM_EN adds a running XOR
// checksum of every sampled word (dropped samples included).
module public_test_capture
    import public_test_capture_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_cycles,
    input  logic [DATA_W-1:0] o_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
`ifdef PUBLIC_TEST_CAPTURE_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_e            state_q;
    logic [CNT_W-1:0]  remaining_q;
    logic              busy_q;
    logic              done_q;
    logic              overflow_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_one_left;
    logic              pop_c;
    logic              push_c;
    logic              drop_c;
    logic              drained_c;

    assign pop_c     = !fifo_empty && out_ready;
    assign push_c    = (state_q == CAPTURE);
    assign drop_c    = push_c && fifo_full && !pop_c;
    // FIFO is empty after this edge, counting a pop of the final entry.
    assign drained_c = fifo_empty || (pop_c && fifo_one_left);

    capture_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_c),
        .data_i     (o_in),
        .pop_i      (pop_c),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .one_left_o (fifo_one_left),
        .head_o     (out_data)
    );

    // Run control: state, sample counter, and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        remaining_q <= num_cycles;
                        overflow_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= (num_cycles == '0) ? DRAIN : CAPTURE;
                    end
                end
                CAPTURE: begin
                    remaining_q <= remaining_q - CNT_W'(1);
                    if (drop_c) begin
                        overflow_q <= 1'b1;
                    end
                    if (remaining_q == CNT_W'(1)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained_c) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = !fifo_empty;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

`ifdef PUBLIC_TEST_CAPTURE_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    // Running XOR of every sampled word; cleared when a run is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            checksum_q <= '0;
        end else if (state_q == CAPTURE) begin
            checksum_q <= checksum_q ^ o_in;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_public_test_capture.sv
// Directed bench for public_test_capture: queue-based reference model checked
// every cycle, plus literal expectations per scenario.
module tb_public_test_capture;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_cycles;
    logic [DW-1:0] o_in;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          overflow;
`ifdef PUBLIC_TEST_CAPTURE_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    public_test_capture #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_cycles (num_cycles),
        .o_in       (o_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
`ifdef PUBLIC_TEST_CAPTURE_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: what the stage must hold after each edge.
    logic [DW-1:0] m_q[$];
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    bit            m_ovf  = 1'b0;
    logic [DW-1:0] m_csum = '0;
    int            m_left = 0;
    int            m_pre;
    bit            m_pop;

    always @(posedge clk) begin
        m_pre = m_q.size();
        m_pop = (m_pre != 0) && out_ready;
        if (rst) begin
            m_q.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_csum = '0;
            m_left = 0;
        end else begin
            if (m_pop) void'(m_q.pop_front());
            if (m_done) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_left = int'(num_cycles);
                    m_ovf  = 1'b0;
                    m_csum = '0;
                end
            end else if (m_left > 0) begin
                m_csum = m_csum ^ o_in;
                if (m_pre < int'(DEPTH) || m_pop) m_q.push_back(o_in);
                else m_ovf = 1'b1;
                m_left--;
            end else if (m_q.size() == 0) begin
                m_done = 1'b1;
            end
        end
    end

    // Observation: accepted words, cycle index, and pulse/level tallies.
    logic [DW-1:0] got[$];
    int cyc = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int valid_cnt = 0;
    int last_done_cyc = -1;

    always @(posedge clk) begin
        cyc++;
        if (!rst && out_valid && out_ready) got.push_back(out_data);
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (out_valid) valid_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle_check();
        chk("cyc_out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("cyc_out_data", out_data, m_q[0]);
        chk("cyc_busy", busy, m_busy);
        chk("cyc_done", done, m_done);
        chk("cyc_overflow", overflow, m_ovf);
`ifdef PUBLIC_TEST_CAPTURE_CHECKSUM_EN
        chk("cyc_checksum", checksum, m_csum);
`endif
    endtask

    task automatic feed(input logic [DW-1:0] w);
        o_in = w;
        @(negedge clk);
    endtask

    task automatic begin_run(input logic [CW-1:0] n, output int t0);
        start      = 1'b1;
        num_cycles = n;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < max_cyc);
        chk(name, busy, 1'b0);
    endtask

    task automatic chk_stream(input string name, input int g0, input logic [DW-1:0] exp[$]);
        chk({name, "_count"}, got.size() - g0, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (g0 + i < got.size()) chk({name, "_word"}, got[g0 + i], exp[i]);
        end
    endtask

    initial begin
        int t0;
        int g0;
        int d0;
        int b0;
        int v0;
        logic [DW-1:0] exp_q[$];

        rst        = 1'b1;
        start      = 1'b0;
        num_cycles = '0;
        o_in       = '0;
        out_ready  = 1'b0;

        fork
            forever begin
                @(negedge clk);
                cycle_check();
            end
        join_none

        repeat (2) @(negedge clk);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
`ifdef PUBLIC_TEST_CAPTURE_CHECKSUM_EN
        chk("rst_checksum", checksum, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Four words, always-ready consumer.
        g0 = got.size(); d0 = done_cnt;
        out_ready = 1'b1;
        begin_run(16'd4, t0);
        feed(32'h11); feed(32'h22); feed(32'h33); feed(32'h44);
        wait_idle("t1_idle", 50);
        exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        chk_stream("t1_stream", g0, exp_q);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_done_time", last_done_cyc - t0, 5);
        chk("t1_overflow", overflow, 0);
`ifdef PUBLIC_TEST_CAPTURE_CHECKSUM_EN
        chk("t1_checksum", checksum, 32'h44);
`endif

        // Ten words into eight entries with a stalled consumer.
        g0 = got.size(); d0 = done_cnt;
        out_ready = 1'b0;
        begin_run(16'd10, t0);
        for (int i = 1; i <= 10; i++) feed(32'hA0 + DW'(i));
        repeat (3) @(negedge clk);
        chk("t2_stall_busy", busy, 1);
        chk("t2_stall_overflow", overflow, 1);
        chk("t2_stall_no_done", done_cnt - d0, 0);
        out_ready = 1'b1;
        wait_idle("t2_idle", 50);
        exp_q = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7, 32'hA8};
        chk_stream("t2_stream", g0, exp_q);
        chk("t2_done_once", done_cnt - d0, 1);
        chk("t2_overflow_held", overflow, 1);
`ifdef PUBLIC_TEST_CAPTURE_CHECKSUM_EN
        chk("t2_checksum", checksum, 32'h0B);
`endif

        // Zero-length run.
        d0 = done_cnt; b0 = busy_cnt; v0 = valid_cnt;
        begin_run(16'd0, t0);
        wait_idle("t3_idle", 20);
        chk("t3_no_valid", valid_cnt - v0, 0);
        chk("t3_done_once", done_cnt - d0, 1);
        chk("t3_done_time", last_done_cyc - t0, 1);
        chk("t3_busy_cycles", busy_cnt - b0, 2);
        chk("t3_overflow", overflow, 0);

        // Start during capture must be ignored.
        g0 = got.size(); d0 = done_cnt;
        begin_run(16'd5, t0);
        feed(32'h51); feed(32'h52);
        start = 1'b1; num_cycles = 16'd3;
        feed(32'h53);
        start = 1'b0;
        feed(32'h54); feed(32'h55);
        wait_idle("t4_idle", 50);
        repeat (3) @(negedge clk);
        exp_q = '{32'h51, 32'h52, 32'h53, 32'h54, 32'h55};
        chk_stream("t4_stream", g0, exp_q);
        chk("t4_done_once", done_cnt - d0, 1);
        chk("t4_still_idle", busy, 0);
`ifdef PUBLIC_TEST_CAPTURE_CHECKSUM_EN
        chk("t4_checksum", checksum, 32'h51);
`endif

        // Reset mid-run after three of six samples.
        d0 = done_cnt;
        out_ready = 1'b0;
        begin_run(16'd6, t0);
        feed(32'h61); feed(32'h62); feed(32'h63);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_overflow", overflow, 0);
        chk("t5_out_data", out_data, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_stays_idle", busy, 0);

        // FIFO fills, then full-with-pop every cycle: no drops.
        g0 = got.size(); d0 = done_cnt;
        out_ready = 1'b0;
        begin_run(16'd20, t0);
        for (int i = 1; i <= 8; i++) feed(32'h100 + DW'(i));
        out_ready = 1'b1;
        for (int i = 9; i <= 20; i++) feed(32'h100 + DW'(i));
        wait_idle("t6_idle", 60);
        exp_q.delete();
        for (int i = 1; i <= 20; i++) exp_q.push_back(32'h100 + DW'(i));
        chk_stream("t6_stream", g0, exp_q);
        chk("t6_done_once", done_cnt - d0, 1);
        chk("t6_overflow", overflow, 0);
`ifdef PUBLIC_TEST_CAPTURE_CHECKSUM_EN
        chk("t6_checksum", checksum, 32'h14);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
